// File: rtl/demux1to3_buf_pkg.sv
// Shared SAYAC definitions: destination encoding and the sel1 > sel2 > sel3 priority decode.
package demux1to3_buf_pkg;

  typedef logic [1:0] dest_t;

  localparam dest_t DEST_NONE = 2'd0;
  localparam dest_t DEST_1    = 2'd1;
  localparam dest_t DEST_2    = 2'd2;
  localparam dest_t DEST_3    = 2'd3;

  function automatic dest_t decode_dest(input logic sel1, input logic sel2, input logic sel3);
    if (sel1) return DEST_1;
    if (sel2) return DEST_2;
    if (sel3) return DEST_3;
    return DEST_NONE;
  endfunction

endpackage

// File: rtl/demux1to3_buf_out_slot.sv
// One-entry output register slice; a load wins over a simultaneous drain.
module out_slot #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] loadData,
  output logic [N-1:0] outData,
  output logic         outValid,
  input  logic         outReady
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = loadData;
      valid_d = 1'b1;
    end else if (valid_q && outReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign outData  = data_q;
  assign outValid = valid_q;

endmodule

// File: rtl/demux1to3_buf.sv
// Registered 1-to-3 priority demux with per-port one-entry buffers and a dropped-word counter.
module demux1to3_buf
  import demux1to3_buf_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  inData,
  input  logic          inValid,
  input  logic          sel1,
  input  logic          sel2,
  input  logic          sel3,
  output logic          inReady,
  output logic [N-1:0]  out1Data,
  output logic [N-1:0]  out2Data,
  output logic [N-1:0]  out3Data,
  output logic          out1Valid,
  output logic          out2Valid,
  output logic          out3Valid,
  input  logic          out1Ready,
  input  logic          out2Ready,
  input  logic          out3Ready,
  output logic [CW-1:0] dropCount
);

  dest_t         dest;
  logic          xfer;
  logic [2:0]    load;
  logic [CW-1:0] drop_q, drop_d;

  assign dest = decode_dest(sel1, sel2, sel3);

  // A slot can accept when empty or when its current word drains this same cycle.
  always_comb begin
    inReady = 1'b1;
    unique case (dest)
      DEST_1:  inReady = !out1Valid || out1Ready;
      DEST_2:  inReady = !out2Valid || out2Ready;
      DEST_3:  inReady = !out3Valid || out3Ready;
      default: inReady = 1'b1;
    endcase
    if (rst) inReady = 1'b0;
  end

  assign xfer = inValid && inReady;

  always_comb begin
    load   = 3'b000;
    drop_d = drop_q;
    if (xfer) begin
      unique case (dest)
        DEST_1:  load = 3'b001;
        DEST_2:  load = 3'b010;
        DEST_3:  load = 3'b100;
        default: drop_d = drop_q + CW'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign dropCount = drop_q;

  out_slot #(.N(N)) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[0]),
    .loadData (inData),
    .outData  (out1Data),
    .outValid (out1Valid),
    .outReady (out1Ready)
  );

  out_slot #(.N(N)) u_slot2 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[1]),
    .loadData (inData),
    .outData  (out2Data),
    .outValid (out2Valid),
    .outReady (out2Ready)
  );

  out_slot #(.N(N)) u_slot3 (
    .clk      (clk),
    .rst      (rst),
    .load     (load[2]),
    .loadData (inData),
    .outData  (out3Data),
    .outValid (out3Valid),
    .outReady (out3Ready)
  );

endmodule

// File: tb/tb_demux1to3_buf.sv
// Randomized and directed bench for demux1to3_buf against a per-port occupancy model.
module tb_demux1to3_buf;

  localparam int N  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic [2:0]    sel;
  logic          in_ready;
  logic [N-1:0]  od [3];
  logic [2:0]    ov;
  logic [2:0]    out_rdy;
  logic [CW-1:0] drop_count;

  int n_chk = 0;
  int n_err = 0;

  // Model: each port holds at most one pending word; the last word written to a port stays
  // visible on its data output after it drains.
  int         m_occ  [3];
  logic [N-1:0] m_last [3];
  int         m_drop;
  logic       last_rdy;

  always #5 clk = ~clk;

  demux1to3_buf #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .inData    (in_data),
    .inValid   (in_valid),
    .sel1      (sel[0]),
    .sel2      (sel[1]),
    .sel3      (sel[2]),
    .inReady   (in_ready),
    .out1Data  (od[0]),
    .out2Data  (od[1]),
    .out3Data  (od[2]),
    .out1Valid (ov[0]),
    .out2Valid (ov[1]),
    .out3Valid (ov[2]),
    .out1Ready (out_rdy[0]),
    .out2Ready (out_rdy[1]),
    .out3Ready (out_rdy[2]),
    .dropCount (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dest_of(input logic [2:0] s);
    for (int k = 0; k < 3; k++) if (s[k]) return k + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_occ[k]  = 0;
      m_last[k] = '0;
    end
    m_drop = 0;
  endtask

  // Check current outputs against the model, then advance the model across one clock edge.
  task automatic step();
    int   d;
    logic exp_rdy;
    #2;
    d = dest_of(sel);
    if (rst)         exp_rdy = 1'b0;
    else if (d == 0) exp_rdy = 1'b1;
    else             exp_rdy = (m_occ[d-1] == 0) || out_rdy[d-1];
    last_rdy = exp_rdy;
    check("inReady", 32'(in_ready), 32'(exp_rdy));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out%0dValid", k + 1), 32'(ov[k]), 32'(m_occ[k] != 0));
      check($sformatf("out%0dData", k + 1), 32'(od[k]), 32'(m_last[k]));
    end
    check("dropCount", 32'(drop_count), 32'(m_drop));
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) if (m_occ[k] != 0 && out_rdy[k]) m_occ[k] = 0;
      if (in_valid && exp_rdy) begin
        if (d == 0) m_drop = (m_drop + 1) % (1 << CW);
        else begin
          m_occ[d-1]  = 1;
          m_last[d-1] = in_data;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic [N-1:0] dat);
    in_valid = 1'b1;
    sel      = s;
    in_data  = dat;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; sel = 3'b001; in_data = 16'hAAAA; out_rdy = 3'b000;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held two cycles with a sel1 word offered: nothing loads.
    step();
    step();
    rst = 1'b0;

    // Priority: all selects set goes to port 1.
    send(3'b111, 16'h1234);
    in_valid = 1'b0; sel = 3'b000;
    step();
    check("prio_out1Data", 32'(od[0]), 32'h1234);

    // Backpressure isolation on port 2.
    out_rdy = 3'b000;
    send(3'b010, 16'h0002);
    send(3'b010, 16'h0022);
    send(3'b010, 16'h0022);
    send(3'b100, 16'h0033);
    in_valid = 1'b0;
    step();
    check("iso_out2Data", 32'(od[1]), 32'h0002);
    check("iso_out3Data", 32'(od[2]), 32'h0033);

    // Streaming eight words through port 1 with the consumer always ready.
    out_rdy = 3'b111;
    step();
    for (int i = 0; i < 8; i++) send(3'b001, 16'(i));
    in_valid = 1'b0;
    step();

    // Drop counter wrap: 257 unselected words from zero.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 257; i++) send(3'b000, 16'(i));
    in_valid = 1'b0;
    step();
    check("wrap_dropCount", 32'(drop_count), 32'd1);

    // Reset in mid-operation with a sel2 transfer offered.
    rst = 1'b1;
    step();
    rst = 1'b0; out_rdy = 3'b000;
    for (int i = 0; i < 5; i++) send(3'b000, 16'h00D0);
    send(3'b001, 16'h0101);
    send(3'b100, 16'h0303);
    rst = 1'b1;
    send(3'b010, 16'h0202);
    rst = 1'b0;
    check("rst_out2Valid", 32'(ov[1]), 32'd0);
    send(3'b010, 16'h0404);
    in_valid = 1'b0;
    step();

    // Random traffic with occasional reset; producer holds while stalled.
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !last_rdy && !rst)) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        sel      = 3'($urandom);
        in_data  = 16'($urandom);
      end
      out_rdy = 3'($urandom);
      rst     = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
